// File: rtl/rx_readout_sched.sv
// Round-robin readout scheduler: grants one receiver channel at a time and streams its I/Q/high-byte words into the readout FIFO.
// Optional feature macro: RX_SCHED_WB_EN adds a strict-priority wideband request.
module rx_readout_sched #(
  parameter int unsigned NRX     = 8,
  parameter int unsigned RXN_W   = 4,
  parameter int unsigned WB_CHAN = 15
) (
  input  logic             adc_clk,
  input  logic             reset_n,
  input  logic [NRX-1:0]   rx_avail,
`ifdef RX_SCHED_WB_EN
  input  logic             rx_avail_wb,
`endif
  input  logic [15:0]      rx_dout,
  output logic [RXN_W-1:0] rx_sel,
  output logic             rd_getI,
  output logic             rd_getQ,
  output logic             rd_getWB,
  input  logic             wr_full,
  output logic             wr_en,
  output logic [15:0]      wr_data,
  output logic [NRX-1:0]   overrun,
  input  logic             ovr_clr,
  output logic [15:0]      count
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_Q = 2'd2,
    RD_H = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NRX-1:0]   pend_q, pend_d;
  logic [NRX-1:0]   ovr_q, ovr_d;
  logic [RXN_W-1:0] ptr_q, ptr_d;
  logic [RXN_W-1:0] rx_sel_q, rx_sel_d;
  logic             rd_geti_q, rd_getq_q;
  logic             wr_en_q, wr_en_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [DW-1:0]    count_q, count_d;

  logic             grant_c;
  logic             grant_ch_c;
  logic             wb_req_c;
  logic             any_req_c;
  logic [RXN_W-1:0] rr_idx_c;
  logic [NRX-1:0]   clr_c;

  assign any_req_c  = (|pend_q) | wb_req_c;
  assign grant_ch_c = grant_c & ~wb_req_c;

  // Next-state logic; a grant is issued on every transition into RD_I.
  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d = RD_I;
          grant_c = 1'b1;
        end
      end
      RD_I: if (!wr_full) state_d = RD_Q;
      RD_Q: if (!wr_full) state_d = RD_H;
      RD_H: begin
        if (!wr_full) begin
          if (any_req_c) begin
            state_d = RD_I;
            grant_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pick: lowest pending index above the pointer, else lowest pending overall.
  always_comb begin
    logic             hi_found;
    logic [RXN_W-1:0] hi_idx;
    logic [RXN_W-1:0] lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = int'(NRX) - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        lo_idx = RXN_W'(k);
        if (k > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = RXN_W'(k);
        end
      end
    end
    rr_idx_c = hi_found ? hi_idx : lo_idx;
  end

  // Pending and sticky overrun bits; a new request beats a coincident clear.
  always_comb begin
    clr_c = '0;
    for (int k = 0; k < int'(NRX); k++) begin
      clr_c[k] = grant_ch_c && (rr_idx_c == RXN_W'(k));
    end
    pend_d = rx_avail | (pend_q & ~clr_c);
    ovr_d  = (ovr_clr ? '0 : ovr_q) | (rx_avail & pend_q & ~clr_c);
  end

  always_comb begin
    ptr_d     = grant_ch_c ? rr_idx_c : ptr_q;
    rx_sel_d  = rx_sel_q;
    if (grant_c) rx_sel_d = wb_req_c ? RXN_W'(WB_CHAN) : rr_idx_c;
    wr_en_d   = (state_q != IDLE) && !wr_full;
    wr_data_d = wr_en_d ? rx_dout : wr_data_q;
    count_d   = (state_q == RD_H && !wr_full) ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      ovr_q     <= '0;
      ptr_q     <= RXN_W'(NRX - 1);
      rx_sel_q  <= '0;
      rd_geti_q <= 1'b0;
      rd_getq_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      ptr_q     <= ptr_d;
      rx_sel_q  <= rx_sel_d;
      rd_geti_q <= (state_d == RD_I);
      rd_getq_q <= (state_d == RD_Q);
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
    end
  end

`ifdef RX_SCHED_WB_EN
  logic pend_wb_q, pend_wb_d;
  logic ovr_wb_q, ovr_wb_d;
  logic sel_wb_q, sel_wb_d;
  logic rd_getwb_q;

  assign wb_req_c = pend_wb_q;

  // Wideband request: strict priority, internal overrun only.
  always_comb begin
    pend_wb_d = rx_avail_wb | (pend_wb_q & ~grant_c);
    ovr_wb_d  = (ovr_clr ? 1'b0 : ovr_wb_q) | (rx_avail_wb & pend_wb_q & ~grant_c);
    sel_wb_d  = grant_c ? wb_req_c : sel_wb_q;
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_wb_q  <= 1'b0;
      ovr_wb_q   <= 1'b0;
      sel_wb_q   <= 1'b0;
      rd_getwb_q <= 1'b0;
    end else begin
      pend_wb_q  <= pend_wb_d;
      ovr_wb_q   <= ovr_wb_d;
      sel_wb_q   <= sel_wb_d;
      rd_getwb_q <= (state_d != IDLE) && sel_wb_d;
    end
  end

  assign rd_getWB = rd_getwb_q;
`else
  assign wb_req_c = 1'b0;
  assign rd_getWB = 1'b0;
`endif

  assign rx_sel  = rx_sel_q;
  assign rd_getI = rd_geti_q;
  assign rd_getQ = rd_getq_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign overrun = ovr_q;
  assign count   = count_q;

endmodule

// File: tb/tb_rx_readout_sched.sv
// Scoreboard bench for rx_readout_sched: expected FIFO words (with write cycle) are queued by stimulus and checked by a monitor.
module tb_rx_readout_sched;

  localparam int unsigned NRX   = 8;
  localparam int unsigned RXN_W = 4;

  logic             clk;
  logic             reset_n;
  logic [NRX-1:0]   rx_avail;
  logic [15:0]      rx_dout;
  logic [RXN_W-1:0] rx_sel;
  logic             rd_getI, rd_getQ, rd_getWB;
  logic             wr_full;
  logic             wr_en;
  logic [15:0]      wr_data;
  logic [NRX-1:0]   overrun;
  logic             ovr_clr;
  logic [15:0]      count;

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  rx_readout_sched #(.NRX(NRX), .RXN_W(RXN_W), .WB_CHAN(15)) dut (
    .adc_clk  (clk),
    .reset_n  (reset_n),
    .rx_avail (rx_avail),
    .rx_dout  (rx_dout),
    .rx_sel   (rx_sel),
    .rd_getI  (rd_getI),
    .rd_getQ  (rd_getQ),
    .rd_getWB (rd_getWB),
    .wr_full  (wr_full),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: high byte tags the word (0A=I, 0B=Q, 0C=high bytes), low byte is the channel.
  always_comb begin
    if (rd_getI)      rx_dout = {8'h0A, 4'h0, rx_sel};
    else if (rd_getQ) rx_dout = {8'h0B, 4'h0, rx_sel};
    else              rx_dout = {8'h0C, 4'h0, rx_sel};
  end

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      exp_t e;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: got %h at cycle %0d, required no write", wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (wr_data !== e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors = errors + 1;
          $display("FAIL write_word: got %h at cycle %0d, required %h at cycle %0d",
                   wr_data, cyc, e.d, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_chan(input int ch, input int first_cyc);
    exp_t e;
    e.d = 16'h0A00 | 16'(ch); e.cyc = first_cyc;     exp_q.push_back(e);
    e.d = 16'h0B00 | 16'(ch); e.cyc = first_cyc + 1; exp_q.push_back(e);
    e.d = 16'h0C00 | 16'(ch); e.cyc = first_cyc + 2; exp_q.push_back(e);
  endtask

  task automatic pulse_avail(input logic [NRX-1:0] v);
    rx_avail = v;
    tick(1);
    rx_avail = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int c;
    exp_t e;
    reset_n  = 1'b0;
    rx_avail = '0;
    wr_full  = 1'b0;
    ovr_clr  = 1'b0;
    do_reset();

    check("reset_rx_sel",  32'(rx_sel), 32'd0);
    check("reset_getI",    32'(rd_getI), 32'd0);
    check("reset_getQ",    32'(rd_getQ), 32'd0);
    check("reset_getWB",   32'(rd_getWB), 32'd0);
    check("reset_wr_en",   32'(wr_en), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_count",   32'(count), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);

    // Single request on channel 3: writes at t+3..t+5.
    c = cyc;
    push_chan(3, c + 3);
    pulse_avail(8'h08);
    tick(9);
    drained("single_drain");
    check("single_count",  32'(count), 32'd1);
    check("single_rx_sel", 32'(rx_sel), 32'd3);

    // Round robin continues after channel 3: 5 before 1.
    c = cyc;
    push_chan(5, c + 3);
    push_chan(1, c + 6);
    pulse_avail(8'h22);
    tick(12);
    drained("rr_drain");
    check("rr_count", 32'(count), 32'd3);

    // All channels at once: 24 back-to-back writes, channels 0..7.
    do_reset();
    c = cyc;
    for (int k = 0; k < 8; k++) push_chan(k, c + 3 + 3 * k);
    pulse_avail(8'hFF);
    tick(30);
    drained("all_drain");
    check("all_count", 32'(count), 32'd8);
    check("all_overrun", 32'(overrun), 32'd0);

    // Four-cycle stall in RD_Q: Q and H writes slip by 4.
    do_reset();
    c = cyc;
    e.d = 16'h0A02; e.cyc = c + 3; exp_q.push_back(e);
    e.d = 16'h0B02; e.cyc = c + 8; exp_q.push_back(e);
    e.d = 16'h0C02; e.cyc = c + 9; exp_q.push_back(e);
    pulse_avail(8'h04);
    tick(2);
    check("stall_in_rdq", 32'(rd_getQ), 32'd1);
    wr_full = 1'b1;
    tick(4);
    wr_full = 1'b0;
    tick(10);
    drained("stall_drain");
    check("stall_count", 32'(count), 32'd1);

    // Overrun: channel 5 re-requested while still waiting behind channel 0.
    do_reset();
    c = cyc;
    push_chan(0, c + 3);
    push_chan(5, c + 6);
    pulse_avail(8'h21);
    pulse_avail(8'h20);
    tick(1);
    check("ovr_set", 32'(overrun), 32'h20);
    tick(10);
    drained("ovr_drain");
    check("ovr_count", 32'(count), 32'd2);
    check("ovr_sticky", 32'(overrun), 32'h20);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'h00);

    // Reset asserted during RD_Q aborts the sample.
    do_reset();
    c = cyc;
    e.d = 16'h0A06; e.cyc = c + 3; exp_q.push_back(e);
    pulse_avail(8'h40);
    tick(2);
    #5;
    reset_n = 1'b0;
    #1;
    check("abort_rx_sel",  32'(rx_sel), 32'd0);
    check("abort_getQ",    32'(rd_getQ), 32'd0);
    check("abort_wr_en",   32'(wr_en), 32'd0);
    check("abort_wr_data", 32'(wr_data), 32'd0);
    check("abort_count",   32'(count), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    drained("abort_drain");
    check("abort_count_after", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
